// File: rtl/alu_share_arbiter.sv
// Purpose : shares one combinational ALU between two requesters with round-robin arbitration.
// Latency : accept in T, ALU evaluated in T+1, registered response valid from T+2 (one op per 3 cycles peak).
// Backpressure: response holds stable while rsp_ready=0; no new request is accepted until the response handshakes.
//
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   reqN_valid/ready/op/a/b (N=0,1)  request channels; req0 = execute path, req1 = auxiliary port
//   alu_ctrl, alu_a, alu_b           latched operation driven to the shared ALU
//   alu_result                       combinational result returned by the ALU
//   rsp_valid/ready/id/data/err      response channel; data forced to 0 when the code is illegal

module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,

    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_prio;     // 1: req1 wins a tie, 0: req0 wins a tie
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_id;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp_err;

    logic w_can_grant;
    logic w_grant1;
    logic w_rdy0;
    logic w_rdy1;
    logic w_legal;

    // reset_n gates ready directly so no handshake can be seen while reset is held.
    assign w_can_grant = (r_state == IDLE) && reset_n;
    assign w_grant1    = req1_valid && (!req0_valid || r_prio);
    assign w_rdy0      = w_can_grant && req0_valid && !w_grant1;
    assign w_rdy1      = w_can_grant && w_grant1;

    assign req0_ready  = w_rdy0;
    assign req1_ready  = w_rdy1;

    // Codes the decoder can actually emit; anything else is trapped as an error.
    always_comb begin
        w_legal = 1'b0;
        case (r_op)
            4'b0000, 4'b0001, 4'b0010, 4'b0011,
            4'b0101, 4'b0110, 4'b0111, 4'b1000,
            4'b1001, 4'b1010: w_legal = 1'b1;
            default:          w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_prio      <= 1'b0;
            r_op        <= 4'b0000;
            r_a         <= '0;
            r_b         <= '0;
            r_id        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rdy0 || w_rdy1) begin
                        r_op    <= w_rdy1 ? req1_op : req0_op;
                        r_a     <= w_rdy1 ? req1_a  : req0_a;
                        r_b     <= w_rdy1 ? req1_b  : req0_b;
                        r_id    <= w_rdy1;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_rsp_data  <= w_legal ? alu_result : '0;
                    r_rsp_err   <= !w_legal;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        // Favour the other requester after every completed response.
                        r_prio      <= !r_rsp_id;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // ALU inputs always mirror the latched operation, including outside EXEC.
    assign alu_ctrl  = r_op;
    assign alu_a     = r_a;
    assign alu_b     = r_b;

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

endmodule
